// File: rtl/bp_pkg.sv
// Shared widths, table entry layout and write-port opcodes for the 1-bit branch predictor.
// Table geometry is owned here; the parameters on the top and table default to these values.
package bp_pkg;

    localparam int IDX_BITS_DEF = 4;
    localparam int PC_W_DEF     = 32;
    localparam int TAG_W        = PC_W_DEF - IDX_BITS_DEF - 2;

    localparam logic [PC_W_DEF-1:0] PC_INC = PC_W_DEF'(4);

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [PC_W_DEF-1:0] target;
        logic                dir;
    } bht_entry_t;

    // Write-port command: allocate/replace on taken, clear direction only on a tag hit.
    typedef enum logic [1:0] {
        WR_NONE    = 2'd0,
        WR_ALLOC   = 2'd1,
        WR_CLR_DIR = 2'd2
    } wr_op_e;

endpackage

// File: rtl/bp_table.sv
// Direct-mapped branch target table held in flops: one combinational read port,
// one synchronous write port and an asynchronous clear of every entry.
module bp_table
    import bp_pkg::*;
#(
    parameter int IDX_BITS = IDX_BITS_DEF
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output bht_entry_t          rd_entry_o,
    input  wr_op_e              wr_op_i,
    input  logic [IDX_BITS-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]    wr_tag_i,
    input  logic [PC_W_DEF-1:0] wr_target_i,
    output wr_op_e              dbg_wr_op_o
);

    localparam int ENTRIES = 1 << IDX_BITS;

    bht_entry_t table_q [ENTRIES];
    bht_entry_t table_d [ENTRIES];

    // Reads see the stored contents; a same-cycle write lands on the next edge.
    assign rd_entry_o  = table_q[rd_idx_i];
    assign dbg_wr_op_o = wr_op_i;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            table_d[i] = table_q[i];
        end
        case (wr_op_i)
            WR_ALLOC: begin
                table_d[wr_idx_i].valid  = 1'b1;
                table_d[wr_idx_i].tag    = wr_tag_i;
                table_d[wr_idx_i].target = wr_target_i;
                table_d[wr_idx_i].dir    = 1'b1;
            end
            WR_CLR_DIR: begin
                if (table_q[wr_idx_i].valid && (table_q[wr_idx_i].tag == wr_tag_i)) begin
                    table_d[wr_idx_i].dir = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

endmodule

// File: rtl/branch_predictor_1bit.sv
// 1-bit direction predictor with direct-mapped BTB: zero-latency IF lookup,
// EX-stage update, registered one-cycle MISS pulse with its redirect PC.
module branch_predictor_1bit
    import bp_pkg::*;
#(
    parameter int IDX_BITS = IDX_BITS_DEF,
    parameter int PC_W     = PC_W_DEF
) (
    input  logic            CLOCK,
    input  logic            RESET_N,
    input  logic [PC_W-1:0] PC_IF,
    output logic            PRED_TAKEN,
    output logic [PC_W-1:0] PRED_TARGET,
    input  logic            RES_VALID,
    input  logic [PC_W-1:0] RES_PC,
    input  logic            RES_TAKEN,
    input  logic [PC_W-1:0] RES_TARGET,
    input  logic            RES_PRED_TAKEN,
    input  logic [PC_W-1:0] RES_PRED_TARGET,
    output logic            MISS,
    output logic [PC_W-1:0] REDIRECT_PC
);

    // RES_VALID qualifies every RES_* input for exactly one cycle; there is no
    // back-pressure, so the pipeline must drop it for squashed instructions.

    bht_entry_t          rd_entry;
    wr_op_e              wr_op;
    wr_op_e              dbg_wr_op;
    logic                hit;
    logic                mispredict;
    logic                miss_q, miss_d;
    logic [PC_W-1:0]     redirect_q, redirect_d;
    logic                unused_ok;

    assign unused_ok = ^{PC_IF[1:0], RES_PC[1:0], dbg_wr_op};

    bp_table #(
        .IDX_BITS (IDX_BITS)
    ) u_table (
        .clk_i       (CLOCK),
        .rst_n_i     (RESET_N),
        .rd_idx_i    (PC_IF[IDX_BITS+1:2]),
        .rd_entry_o  (rd_entry),
        .wr_op_i     (wr_op),
        .wr_idx_i    (RES_PC[IDX_BITS+1:2]),
        .wr_tag_i    (RES_PC[PC_W-1:IDX_BITS+2]),
        .wr_target_i (RES_TARGET),
        .dbg_wr_op_o (dbg_wr_op)
    );

    assign hit         = rd_entry.valid && (rd_entry.tag == PC_IF[PC_W-1:IDX_BITS+2]);
    assign PRED_TAKEN  = hit && rd_entry.dir;
    assign PRED_TARGET = PRED_TAKEN ? rd_entry.target : (PC_IF + PC_INC);

    always_comb begin
        wr_op = WR_NONE;
        if (RES_VALID) begin
            wr_op = RES_TAKEN ? WR_ALLOC : WR_CLR_DIR;
        end
    end

    // A taken/taken pair still mispredicts when the carried target was stale.
    assign mispredict = RES_VALID &&
                        ((RES_PRED_TAKEN != RES_TAKEN) ||
                         (RES_TAKEN && RES_PRED_TAKEN && (RES_PRED_TARGET != RES_TARGET)));

    always_comb begin
        miss_d     = mispredict;
        redirect_d = redirect_q;
        if (mispredict) begin
            redirect_d = RES_TAKEN ? RES_TARGET : (RES_PC + PC_INC);
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            miss_q     <= 1'b0;
            redirect_q <= '0;
        end else begin
            miss_q     <= miss_d;
            redirect_q <= redirect_d;
        end
    end

    assign MISS        = miss_q;
    assign REDIRECT_PC = redirect_q;

endmodule
